// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: start-edge detect, 3-sample majority per bit,
// start-glitch rejection, parity and one/two stop-bit checking.
module uart_rx_frame_chk #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  input  logic                  Stop2,
  output logic [DATA_W-1:0]     P_Data,
  output logic                  Data_Valid,
  output logic                  Strt_Glitch,
  output logic                  Par_Err,
  output logic                  Stp_Err,
  output logic                  Busy
);

  localparam int B_W = $clog2(DATA_W);
  localparam logic [PRESCALE_W-1:0] P_ONE = 1;
  localparam logic [PRESCALE_W-1:0] P_MIN = 8;
  localparam logic [PRESCALE_W:0]   M_ONE = 1;
  localparam logic [PRESCALE_W:0]   M_TWO = 2;
  localparam logic [B_W-1:0]        B_ONE = 1;
  localparam logic [B_W-1:0]        B_LAST = B_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state, w_next_state;
  logic [PRESCALE_W-1:0] r_e, r_p;
  logic [B_W-1:0]        r_b;
  logic                  r_par_en, r_par_typ, r_stop2;
  logic [2:0]            r_s;
  logic [DATA_W-1:0]     r_shift, r_p_data;
  logic                  r_par_flag, r_stp_flag;
  logic                  r_data_valid, r_strt_glitch, r_par_err, r_stp_err, r_busy;

  logic [PRESCALE_W:0]   w_mid, w_e;
  logic                  w_sample, w_decide, w_last_e, w_maj, w_exp_par, w_last_stop;
  logic                  w_glitch, w_frame_end;

  // Mid-bit arithmetic is one bit wider so mid+2 never wraps.
  assign w_mid       = {1'b0, r_p[PRESCALE_W-1:1]};
  assign w_e         = {1'b0, r_e};
  assign w_sample    = (w_e == w_mid - M_ONE) || (w_e == w_mid) || (w_e == w_mid + M_ONE);
  assign w_decide    = (w_e == w_mid + M_TWO);
  assign w_last_e    = (r_e == r_p - P_ONE);
  assign w_maj       = (r_s[0] & r_s[1]) | (r_s[0] & r_s[2]) | (r_s[1] & r_s[2]);
  assign w_exp_par   = (^r_shift) ^ r_par_typ;
  assign w_last_stop = !r_stop2 || (r_b == B_ONE);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_glitch     = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      IDLE:   if (!RX_IN) w_next_state = START;
      START:  if (w_decide && w_maj) begin
                w_glitch     = 1'b1;
                w_next_state = IDLE;
              end else if (w_last_e) begin
                w_next_state = DATA;
              end
      DATA:   if (w_last_e && r_b == B_LAST) w_next_state = r_par_en ? PARITY : STOP;
      PARITY: if (w_last_e) w_next_state = STOP;
      STOP:   if (w_decide && w_last_stop) begin
                w_frame_end  = 1'b1;
                w_next_state = IDLE;
              end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_e           <= '0;
      r_p           <= P_MIN;
      r_b           <= '0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_stop2       <= 1'b0;
      r_s           <= '0;
      r_shift       <= '0;
      r_p_data      <= '0;
      r_par_flag    <= 1'b0;
      r_stp_flag    <= 1'b0;
      r_data_valid  <= 1'b0;
      r_strt_glitch <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_data_valid  <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_strt_glitch <= w_glitch;
      r_busy        <= (w_next_state != IDLE);

      if (r_state == IDLE) begin
        // The start-edge cycle itself counts as E=0 of the start bit.
        r_e        <= RX_IN ? '0 : P_ONE;
        r_b        <= '0;
        r_par_flag <= 1'b0;
        r_stp_flag <= 1'b0;
        if (!RX_IN) begin
          r_p       <= (Prescale < P_MIN) ? P_MIN : Prescale;
          r_par_en  <= Par_En;
          r_par_typ <= Par_Typ;
          r_stop2   <= Stop2;
        end
      end else begin
        r_e <= (w_last_e || w_next_state == IDLE) ? '0 : r_e + P_ONE;
        if (w_sample) r_s <= {r_s[1:0], RX_IN};
        if (w_decide) begin
          case (r_state)
            DATA:    r_shift <= {w_maj, r_shift[DATA_W-1:1]};
            PARITY:  if (w_maj != w_exp_par) r_par_flag <= 1'b1;
            STOP:    if (!w_maj) r_stp_flag <= 1'b1;
            default: ;
          endcase
        end
        if (w_last_e) begin
          if (r_state == DATA) r_b <= (r_b == B_LAST) ? '0 : r_b + B_ONE;
          if (r_state == STOP) r_b <= r_b + B_ONE;
        end
      end

      if (w_frame_end) begin
        r_p_data     <= r_shift;
        r_data_valid <= !r_par_flag && !r_stp_flag && w_maj;
        r_par_err    <= r_par_flag;
        r_stp_err    <= r_stp_flag || !w_maj;
      end
    end
  end

  assign P_Data      = r_p_data;
  assign Data_Valid  = r_data_valid;
  assign Strt_Glitch = r_strt_glitch;
  assign Par_Err     = r_par_err;
  assign Stp_Err     = r_stp_err;
  assign Busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Scoreboard bench for uart_rx_frame_chk: a line-level model predicts each
// frame outcome and its timing; a monitor compares every DUT pulse.
module tb_uart_rx_frame_chk;
  localparam int DW = 8;
  localparam int PW = 8;

  logic          CLK = 1'b0;
  logic          RST, RX_IN, Par_En, Par_Typ, Stop2;
  logic [PW-1:0] Prescale;
  logic [DW-1:0] P_Data;
  logic          Data_Valid, Strt_Glitch, Par_Err, Stp_Err, Busy;

  uart_rx_frame_chk #(.DATA_W(DW), .PRESCALE_W(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .Par_En(Par_En), .Par_Typ(Par_Typ), .Stop2(Stop2),
    .P_Data(P_Data), .Data_Valid(Data_Valid), .Strt_Glitch(Strt_Glitch),
    .Par_Err(Par_Err), .Stp_Err(Stp_Err), .Busy(Busy)
  );

  typedef struct {
    int            t;
    logic          dv, gl, perr, serr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  bit            line_q[$];
  logic [DW-1:0] model_pdata = '0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic          prev_busy = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Majority of the three mid-bit samples of frame bit k on the driven line.
  function automatic bit line_maj(input int pe, input int k);
    int mid = pe >> 1;
    int s = int'(line_q[k*pe+mid-1]) + int'(line_q[k*pe+mid]) + int'(line_q[k*pe+mid+1]);
    return s >= 2;
  endfunction

  task automatic model_frame(input int t0, input int p_raw, input bit pen, input bit ptyp, input bit st2);
    exp_t          e;
    int            pe = (p_raw < 8) ? 8 : p_raw;
    int            mid = pe >> 1;
    int            n = 2 + DW + int'(pen) + int'(st2);
    logic [DW-1:0] d;
    if (line_maj(pe, 0)) begin
      e.t = t0 + mid + 3; e.dv = 0; e.gl = 1; e.perr = 0; e.serr = 0; e.data = model_pdata;
    end else begin
      for (int i = 0; i < DW; i++) d[i] = line_maj(pe, 1 + i);
      e.perr = pen && (line_maj(pe, 1 + DW) != ((^d) ^ ptyp));
      e.serr = !line_maj(pe, 1 + DW + int'(pen)) || (st2 && !line_maj(pe, 2 + DW + int'(pen)));
      e.dv   = !e.perr && !e.serr;
      e.gl   = 0;
      e.t    = t0 + (n - 1) * pe + mid + 3;
      e.data = d;
      model_pdata = d;
    end
    exp_q.push_back(e);
  endtask

  // One bit cell; low_head drives 0 through the decision window, then idles high.
  task automatic add_bit(input int pe, input bit v, input bit flip, input bit low_head);
    int mid = pe >> 1;
    int fpos = mid - 1 + int'($urandom_range(0, 2));
    bit b;
    for (int e = 0; e < pe; e++) begin
      b = low_head ? (e > mid + 1) : v;
      if (flip && e == fpos) b = ~b;
      line_q.push_back(b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      RX_IN = 1'b1;
    end
  endtask

  task automatic drive_line(input int p_raw, input bit pen, input bit ptyp, input bit st2, input int abort_at);
    int t0;
    for (int i = 0; i < line_q.size(); i++) begin
      @(posedge CLK); #1;
      if (i == abort_at) begin
        RX_IN = 1'b1;
        RST   = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0;
        model_pdata = '0;
        check("abort_p_data", 32'(P_Data), 32'(0));
        check("abort_busy", 32'(Busy), 32'(0));
        return;
      end
      if (i == 0) begin
        Prescale = PW'(p_raw); Par_En = pen; Par_Typ = ptyp; Stop2 = st2;
        t0 = cyc;
        if (abort_at < 0) model_frame(t0, p_raw, pen, ptyp, st2);
      end
      if (i == 2) begin
        Prescale = PW'($urandom); Par_En = 1'($urandom); Par_Typ = 1'($urandom); Stop2 = 1'($urandom);
      end
      RX_IN = line_q[i];
    end
  endtask

  task automatic send_frame(input int p_raw, input bit pen, input bit ptyp, input bit st2,
                            input logic [DW-1:0] d, input bit par_flip, input logic [1:0] stop_low,
                            input logic [11:0] flip_mask, input int abort_bit, input int gap);
    int pe = (p_raw < 8) ? 8 : p_raw;
    int k = 0;
    line_q.delete();
    add_bit(pe, 1'b0, flip_mask[k], 1'b0); k++;
    for (int i = 0; i < DW; i++) begin add_bit(pe, d[i], flip_mask[k], 1'b0); k++; end
    if (pen) begin add_bit(pe, (^d) ^ ptyp ^ par_flip, flip_mask[k], 1'b0); k++; end
    add_bit(pe, 1'b1, flip_mask[k], stop_low[0]); k++;
    if (st2) add_bit(pe, 1'b1, flip_mask[k], stop_low[1]);
    drive_line(p_raw, pen, ptyp, st2, (abort_bit < 0) ? -1 : pe * (1 + abort_bit) + pe / 3);
    idle(gap);
  endtask

  task automatic send_glitch(input int p_raw, input int low_len, input int gap);
    int pe = (p_raw < 8) ? 8 : p_raw;
    line_q.delete();
    for (int i = 0; i < (pe >> 1) + 4; i++) line_q.push_back(i >= low_len);
    drive_line(p_raw, 1'b0, 1'b0, 1'b0, -1);
    idle(gap);
  endtask

  // Monitor: every output pulse pops one prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST !== 1'b1 && (Data_Valid | Strt_Glitch | Par_Err | Stp_Err) === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({Data_Valid, Strt_Glitch, Par_Err, Stp_Err}), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("pulse_time", 32'(cyc), 32'(e.t));
          check("data_valid", 32'(Data_Valid), 32'(e.dv));
          check("strt_glitch", 32'(Strt_Glitch), 32'(e.gl));
          check("par_err", 32'(Par_Err), 32'(e.perr));
          check("stp_err", 32'(Stp_Err), 32'(e.serr));
          check("p_data", 32'(P_Data), 32'(e.data));
          check("busy_low_at_pulse", 32'(Busy), 32'(0));
          check("busy_before_pulse", 32'(prev_busy), 32'(1));
        end
      end
      prev_busy = Busy;
    end
  end

  initial begin
    RST = 1'b1; RX_IN = 1'b1; Prescale = PW'(16); Par_En = 0; Par_Typ = 0; Stop2 = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_p_data", 32'(P_Data), 32'(0));
    check("rst_data_valid", 32'(Data_Valid), 32'(0));
    check("rst_strt_glitch", 32'(Strt_Glitch), 32'(0));
    check("rst_par_err", 32'(Par_Err), 32'(0));
    check("rst_stp_err", 32'(Stp_Err), 32'(0));
    check("rst_busy", 32'(Busy), 32'(0));
    RST = 1'b0;
    idle(4);
    check("idle_busy", 32'(Busy), 32'(0));

    send_frame(16, 0, 0, 0, 8'hA5, 0, 2'b00, 12'h000, -1, 3);   // 8N1 clean frame
    send_glitch(16, 4, 4);                                       // short start pulse
    send_frame(16, 1, 0, 0, 8'h03, 1, 2'b00, 12'h000, -1, 2);   // bad even parity
    send_frame(16, 1, 0, 1, 8'h5C, 0, 2'b10, 12'h000, -1, 2);   // second stop bit low
    send_frame(16, 0, 0, 0, 8'hFF, 0, 2'b00, 12'h1FE, -1, 2);   // single-sample dips in data
    send_frame(16, 0, 0, 0, 8'h3C, 0, 2'b00, 12'h000, -1, 0);   // back to back
    send_frame(16, 0, 0, 0, 8'hC3, 0, 2'b00, 12'h000, -1, 0);
    send_frame(16, 0, 0, 0, 8'h77, 0, 2'b00, 12'h000, 3, 2);    // reset mid-DATA
    send_frame(16, 0, 0, 0, 8'h9E, 0, 2'b00, 12'h000, -1, 2);
    send_frame(5, 1, 1, 0, 8'h6B, 0, 2'b00, 12'h000, -1, 2);    // small prescale clamps to 8
    send_glitch(3, 2, 2);

    for (int n = 0; n < 40; n++) begin
      int p = int'($urandom_range(4, 20));
      if ($urandom_range(0, 5) == 0) begin
        send_glitch(p, int'($urandom_range(1, ((p < 8 ? 8 : p) >> 1) - 1)), int'($urandom_range(0, 3)));
      end else begin
        send_frame(p, 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                   ($urandom_range(0, 1) == 0) ? 12'($urandom) : 12'h000,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DW - 1)) : -1,
                   int'($urandom_range(0, 4)));
      end
    end

    idle(30);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
